// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: inst field positions,
// NOP encodings, FSM state constants and the host push payload.
package seq_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned OP_MM_HI = 31;
  localparam int unsigned OP_MM_LO = 30;
  localparam int unsigned OP_SV_HI = 29;
  localparam int unsigned OP_SV_LO = 28;
  localparam int unsigned OP_SS_HI = 27;
  localparam int unsigned OP_SS_LO = 26;
  localparam int unsigned OP_T_HI  = 25;
  localparam int unsigned OP_T_LO  = 24;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;
  localparam logic [INST_W-1:0] NOP_IO   = 32'h0;

  localparam logic [0:0] ISSUE = 1'b0;
  localparam logic [0:0] WAIT  = 1'b1;

  typedef struct packed {
    logic [INST_W-1:0] io_inst;
    logic [INST_W-1:0] inst;
  } inst_pair_t;

  // True when the instruction carries a matmul opcode.
  function automatic logic is_mm(input logic [INST_W-1:0] i);
    return i[OP_MM_HI:OP_MM_LO] != 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO with flush; pushes while full are dropped.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == LW'(0));
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_sequencer.sv
// Buffers host instruction pairs and issues them to the datapath, inserting
// NOP bubbles after matmul ops. SEQ_PERF_CNT_EN adds issue/stall counters.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MM_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   flush,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [63:0]            push_data,
  output logic [31:0]            inst,
  output logic [31:0]            io_inst,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       issue_cnt,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(MM_LATENCY + 2);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W == 0)) begin : g_param_check
    $error("inst_sequencer: DEPTH must be a power of two >= 2 and CNT_W > 0");
  end

  logic [63:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  inst_pair_t    head;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   inst_d, io_d;
  logic          pop_c;

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push_valid),
    .wdata (push_data),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign head       = fifo_rdata;
  assign push_ready = !fifo_full;
  assign busy       = (level != '0) || (cnt_q != '0);

  // Next-state and issue decode; flush suppresses the pop so nothing flushed leaks out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = NOP_INST;
    io_d    = NOP_IO;
    pop_c   = 1'b0;
    if (state_q == WAIT) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = ISSUE;
    end else if (run && !fifo_empty && !flush) begin
      pop_c  = 1'b1;
      inst_d = head.inst;
      io_d   = head.io_inst;
      if (is_mm(head.inst) && (MM_LATENCY > 0)) begin
        cnt_d   = CW'(MM_LATENCY);
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ISSUE;
      cnt_q   <= '0;
      inst    <= NOP_INST;
      io_inst <= NOP_IO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst    <= inst_d;
      io_inst <= io_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Free-running wrap counters, cleared together with the FIFO.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop_c)            issue_cnt <= issue_cnt + CNT_W'(1);
      if (state_q == WAIT)  stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed self-checking bench for inst_sequencer (DEPTH=8, MM_LATENCY=4).
`timescale 1ns/1ps
module tb_inst_sequencer;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [63:0] push_data;
  logic [31:0] inst;
  logic [31:0] io_inst;
  logic        busy;
  logic [3:0]  level;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  inst_sequencer #(
    .DEPTH      (8),
    .MM_LATENCY (4),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .inst       (inst),
    .io_inst    (io_inst),
    .busy       (busy),
    .level      (level)
`ifdef SEQ_PERF_CNT_EN
    ,
    .issue_cnt  (issue_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; run = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0;
    tick(); tick();
    expect_eq("rst_inst", 64'(inst), 64'h0);
    expect_eq("rst_io", 64'(io_inst), 64'h0);
    expect_eq("rst_level", 64'(level), 64'h0);
    expect_eq("rst_busy", 64'(busy), 64'h0);
    expect_eq("rst_ready", 64'(push_ready), 64'h1);
    rst = 1'b1;

    // Single issue
    run = 1'b1; push_valid = 1'b1; push_data = {32'h0000_0001, 32'h0C00_0000};
    tick();
    push_valid = 1'b0;
    expect_eq("single_pre_inst", 64'(inst), 64'h0);
    expect_eq("single_pre_busy", 64'(busy), 64'h1);
    expect_eq("single_pre_level", 64'(level), 64'h1);
    tick();
    expect_eq("single_inst", 64'(inst), 64'h0C00_0000);
    expect_eq("single_io", 64'(io_inst), 64'h1);
    tick();
    expect_eq("single_nop", 64'(inst), 64'h0);
    expect_eq("single_busy", 64'(busy), 64'h0);

    // Matmul stall
    push_valid = 1'b1; push_data = {32'h0000_000A, 32'h4000_0000};
    tick();
    push_data = {32'h0000_000B, 32'h1000_0000};
    tick();
    push_valid = 1'b0;
    expect_eq("mm_inst", 64'(inst), 64'h4000_0000);
    expect_eq("mm_io", 64'(io_inst), 64'hA);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_eq($sformatf("mm_bubble%0d", i), 64'({io_inst, inst}), 64'h0);
      expect_eq($sformatf("mm_busy%0d", i), 64'(busy), 64'h1);
    end
    tick();
    expect_eq("mm_next_inst", 64'(inst), 64'h1000_0000);
    expect_eq("mm_next_io", 64'(io_inst), 64'hB);
`ifdef SEQ_PERF_CNT_EN
    expect_eq("mm_stall_cnt", 64'(stall_cnt), 64'd4);
    expect_eq("mm_issue_cnt", 64'(issue_cnt), 64'd3);
`endif

    // Full FIFO with run low
    run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_valid = 1'b1; push_data = {32'(i), 32'h0100_0000 + 32'(i)};
      #1;
      expect_eq($sformatf("full_ready%0d", i), 64'(push_ready), (i < 8) ? 64'h1 : 64'h0);
      tick();
    end
    push_valid = 1'b0;
    expect_eq("full_level", 64'(level), 64'd8);
    expect_eq("full_ready", 64'(push_ready), 64'h0);
    expect_eq("full_no_issue", 64'(inst), 64'h0);
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_eq($sformatf("drain_inst%0d", i), 64'(inst), 64'h0100_0000 + 64'(i));
      expect_eq($sformatf("drain_io%0d", i), 64'(io_inst), 64'(i));
    end
    tick();
    expect_eq("drain_nop", 64'(inst), 64'h0);
    expect_eq("drain_level", 64'(level), 64'h0);

    // run gating during WAIT
    push_valid = 1'b1; push_data = {32'h0000_0000, 32'h4000_0000};
    tick();
    push_data = {32'h0000_0007, 32'h0000_0005};
    tick();
    push_valid = 1'b0; run = 1'b0;
    expect_eq("gate_mm", 64'(inst), 64'h4000_0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_eq($sformatf("gate_nop%0d", i), 64'(inst), 64'h0);
    end
    expect_eq("gate_level", 64'(level), 64'h1);
    run = 1'b1;
    tick();
    expect_eq("gate_resume_inst", 64'(inst), 64'h5);
    expect_eq("gate_resume_io", 64'(io_inst), 64'h7);

    // flush with simultaneous push and run
    run = 1'b0; push_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_data = {32'h0000_0100 + 32'(i), 32'h0200_0000 + 32'(i)};
      tick();
    end
    expect_eq("flush_pre_level", 64'(level), 64'd5);
    flush = 1'b1; run = 1'b1; push_data = {32'hDEAD_BEEF, 32'h0300_0000};
    tick();
    flush = 1'b0; push_valid = 1'b0;
    expect_eq("flush_level", 64'(level), 64'h0);
    expect_eq("flush_nop", 64'(inst), 64'h0);
`ifdef SEQ_PERF_CNT_EN
    expect_eq("flush_issue_cnt", 64'(issue_cnt), 64'h0);
    expect_eq("flush_stall_cnt", 64'(stall_cnt), 64'h0);
`endif
    tick();
    expect_eq("flush_after_nop", 64'(inst), 64'h0);
    expect_eq("flush_after_busy", 64'(busy), 64'h0);

    // Reset mid-WAIT
    push_valid = 1'b1; push_data = {32'h0000_0000, 32'h8000_0000};
    tick();
    push_data = {32'h0000_0001, 32'h0000_0009};
    tick();
    push_valid = 1'b0;
    expect_eq("rwait_mm", 64'(inst), 64'h8000_0000);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    expect_eq("rwait_inst", 64'(inst), 64'h0);
    expect_eq("rwait_level", 64'(level), 64'h0);
    expect_eq("rwait_busy", 64'(busy), 64'h0);
    push_valid = 1'b1; push_data = {32'h0000_0002, 32'h0000_0033};
    tick();
    push_valid = 1'b0;
    tick();
    expect_eq("rwait_issue", 64'(inst), 64'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Instruction sequencer in front of the accelerator datapath top.
- Buffers 64-bit instruction pairs {io_inst, inst} from the host in a small FIFO.
- Issues one pair per cycle onto the datapath's inst/io_inst buses and inserts NOP bubbles while a matmul op is in flight.
- Lets the host stream programs without tracking matmul latency.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- MM_LATENCY, 4, bubble cycles inserted after any instruction with op_mm != 0; 0 = no stall.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-low.
- run  input  1  issue enable; when low, no new pops.
- flush  input  1  synchronous FIFO clear.
- push_valid  input  1  host offers an entry.
- push_ready  output  1  FIFO can accept; = !full.
- push_data  input  64  {io_inst[31:0], inst[31:0]}.
- inst  output  32  to datapath inst; registered.
- io_inst  output  32  to datapath io_inst; registered.
- busy  output  1  FIFO non-empty or stall counter non-zero.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - inst = 0, io_inst = 0; FIFO pointers and level = 0; stall counter = 0; state = ISSUE.
  - Reset overrides everything, including a matmul in flight.
- NOP is all-zero inst and io_inst; it is driven on every cycle without an issue.
- Push: entry is written when push_valid && push_ready at the edge.
  - push_ready is derived from full only; a push while full is dropped even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with 0 < level < DEPTH: level unchanged.
- States:
  - ISSUE: if run && !empty, pop the head and register it onto inst/io_inst. If the popped inst[31:30] (op_mm) != 0 and MM_LATENCY > 0, load counter = MM_LATENCY and go to WAIT. Otherwise stay in ISSUE; if nothing is popped, drive NOP.
  - WAIT: drive NOP and decrement the counter each cycle; go to ISSUE when the counter reaches 1→0. The WAIT path is independent of run and continues draining while run is low.
- Latency:
  - Entry pushed into an empty FIFO at edge t appears on inst after edge t+1, with run high.
  - Back-to-back non-matmul ops issue once per cycle.
  - After a matmul appears at cycle k, the next instruction appears no earlier than k+MM_LATENCY+1.
- flush:
  - Empties the FIFO at the edge and takes priority over a simultaneous push and pop. The flushed entry is not issued; NOP is driven.
  - Does not abort WAIT or alter the registered output of the prior cycle.
- Pointers wrap modulo DEPTH; level saturates structurally at DEPTH (full) and 0 (empty).
- busy = (level != 0) || (counter != 0).

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - Adds output ports issue_cnt [CNT_W-1:0] and stall_cnt [CNT_W-1:0].
  - issue_cnt increments on each pop-and-issue.
  - stall_cnt increments on each WAIT cycle.
  - Both wrap at 2^CNT_W and clear on reset or flush.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - inst field positions (OP_MM_HI = 31, OP_MM_LO = 30, op_sv/op_ss/op_t slices);
  - NOP_INST = 32'h0 and NOP_IO = 32'h0;
  - the state enum {ISSUE, WAIT}.
- One sub-module, sync_fifo, provides the parameterised width/depth storage with push/pop/flush, full/empty and level. The sequencer FSM and stall counter stay in inst_sequencer.

Test Plan:
- Single issue: reset, run = 1, push {32'h0000_0001, 32'h0C00_0000} at t → inst = 32'h0C00_0000 and io_inst = 32'h1 after edge t+1; NOP on the following cycle; busy falls.
- Matmul stall: push matmul inst 32'h4000_0000 then 32'h1000_0000 with MM_LATENCY = 4 → matmul at cycle k, NOP for k+1..k+4, second op at k+5; stall_cnt = 4 if SEQ_PERF_CNT_EN is defined.
- Full FIFO: with run = 0, push 9 entries (DEPTH = 8) → push_ready = 0 after the 8th, the 9th is dropped, level = 8. Then run = 1 → exactly 8 issues in order.
- run gating: deassert run during WAIT → counter still drains to 0; no pop until run = 1 again.
- flush: level = 5, assert flush with a simultaneous push → level = 0, no issue, NOP that cycle.
- Reset mid-WAIT: rst low for one edge during WAIT → inst = 0, level = 0, busy = 0 on the next cycle.
